// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
//   Bundles the D/E/M pipeline signals seen by the hazard controller and
//   the stall/forward controls it returns.
//   master : pipeline side, drives stage info, receives controls
//   slave  : hazard controller side
interface hazard_stall_ctrl_if;
  // D stage
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_Tuse_rs;
  logic [1:0]  D_Tuse_rt;
  logic        D_md_use;
  // E stage
  logic [4:0]  E_RegAddr;
  logic        E_RegWrite;
  logic [1:0]  E_Tnew;
  logic        E_md_start;
  logic        E_md_is_div;
  // M stage
  logic [4:0]  M_RegAddr;
  logic        M_RegWrite;
  logic [1:0]  M_Tnew;
  // controls
  logic        stall;
  logic        PC_en;
  logic        D_en;
  logic        E_clr;
  logic [1:0]  D_fwd_rs;
  logic [1:0]  D_fwd_rt;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md_use,
           E_RegAddr, E_RegWrite, E_Tnew, E_md_start, E_md_is_div,
           M_RegAddr, M_RegWrite, M_Tnew,
    input  stall, PC_en, D_en, E_clr, D_fwd_rs, D_fwd_rt, md_busy, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md_use,
           E_RegAddr, E_RegWrite, E_Tnew, E_md_start, E_md_is_div,
           M_RegAddr, M_RegWrite, M_Tnew,
    output stall, PC_en, D_en, E_clr, D_fwd_rs, D_fwd_rt, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Central hazard unit for the 5-stage MIPS pipeline. Detects RAW hazards
//   between D-stage sources and E/M destinations using Tuse/Tnew, produces
//   the PC/D/E stall and bubble controls and the D-stage forwarding selects,
//   and runs the multiply/divide busy countdown.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - hazard_stall_ctrl_if.slave (stage info in, controls out)
// Optional build macro:
//   HAZARD_STALL_CNT_EN - adds a 32-bit stall-cycle counter on stall_cnt;
//                         otherwise stall_cnt reads 0.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  hazard_stall_ctrl_if.slave bus
);

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  logic [CNT_W-1:0] cnt;
  logic             md_busy;
  logic             stall;

  // A match needs a real (nonzero) source and a writing producer.
  function automatic logic src_match(input logic [4:0] src,
                                     input logic       wr,
                                     input logic [4:0] dst);
    return (src != 5'd0) && wr && (dst == src);
  endfunction

  logic e_rs, m_rs, e_rt, m_rt;
  logic stall_rs, stall_rt, stall_md;

  always_comb begin
    e_rs = src_match(bus.D_rs, bus.E_RegWrite, bus.E_RegAddr);
    m_rs = src_match(bus.D_rs, bus.M_RegWrite, bus.M_RegAddr);
    e_rt = src_match(bus.D_rt, bus.E_RegWrite, bus.E_RegAddr);
    m_rt = src_match(bus.D_rt, bus.M_RegWrite, bus.M_RegAddr);

    // Tuse=3 (unused) can never be below a 2-bit Tnew, so it never stalls.
    stall_rs = (e_rs && (bus.D_Tuse_rs < bus.E_Tnew)) ||
               (m_rs && (bus.D_Tuse_rs < bus.M_Tnew));
    stall_rt = (e_rt && (bus.D_Tuse_rt < bus.E_Tnew)) ||
               (m_rt && (bus.D_Tuse_rt < bus.M_Tnew));
    stall_md = bus.D_md_use && md_busy;
    stall    = stall_rs || stall_rt || stall_md;
  end

  // Forwarding selects: E is the younger producer, so it wins over M.
  always_comb begin
    bus.D_fwd_rs = FWD_GRF;
    if (e_rs && (bus.E_Tnew == 2'd0))      bus.D_fwd_rs = FWD_E;
    else if (m_rs && (bus.M_Tnew == 2'd0)) bus.D_fwd_rs = FWD_M;

    bus.D_fwd_rt = FWD_GRF;
    if (e_rt && (bus.E_Tnew == 2'd0))      bus.D_fwd_rt = FWD_E;
    else if (m_rt && (bus.M_Tnew == 2'd0)) bus.D_fwd_rt = FWD_M;
  end

  // MD busy countdown. A new start reloads even mid-operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (bus.E_md_start)
      cnt <= bus.E_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  // The start cycle itself is busy so a following MD instr stalls at once.
  assign md_busy = bus.E_md_start || (cnt != '0);

  assign bus.stall   = stall;
  assign bus.PC_en   = ~stall;
  assign bus.D_en    = ~stall;
  assign bus.E_clr   = stall;
  assign bus.md_busy = md_busy;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] scnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     scnt <= '0;
    else if (stall) scnt <= scnt + 32'd1;
  end
  assign bus.stall_cnt = scnt;
`else
  assign bus.stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.D_rs = 0; bus.D_rt = 0; bus.D_Tuse_rs = 0; bus.D_Tuse_rt = 0;
    bus.D_md_use = 0;
    bus.E_RegAddr = 0; bus.E_RegWrite = 0; bus.E_Tnew = 0;
    bus.E_md_start = 0; bus.E_md_is_div = 0;
    bus.M_RegAddr = 0; bus.M_RegWrite = 0; bus.M_Tnew = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    bus.E_md_start = 1; bus.E_RegWrite = 1; bus.E_RegAddr = 5'd3;
    step(); step(); step();
    checks++;
    if (bus.md_busy !== 1'b1) begin errors++;
      $display("FAIL reset_busy_start: got %b want 1", bus.md_busy); end
    checks++;
    if (bus.stall_cnt !== 32'h0) begin errors++;
      $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt); end
    bus.E_md_start = 0;
    #1;
    checks++;
    if (bus.md_busy !== 1'b0) begin errors++;
      $display("FAIL reset_cnt_held: md_busy got %b want 0", bus.md_busy); end
    idle();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.stall, bus.PC_en, bus.D_en, bus.E_clr, bus.D_fwd_rs, bus.D_fwd_rt, bus.md_busy} !== 9'b0_1_1_0_00_00_0) begin
      errors++;
      $display("FAIL reset_idle_outputs: got %b want 011000000",
        {bus.stall, bus.PC_en, bus.D_en, bus.E_clr, bus.D_fwd_rs, bus.D_fwd_rt, bus.md_busy});
    end
  endtask

  task automatic test_load_use();
    idle();
    bus.D_rs = 5'd8; bus.D_Tuse_rs = 2'd1;
    bus.E_RegAddr = 5'd8; bus.E_RegWrite = 1; bus.E_Tnew = 2'd2;
    #1;
    checks++;
    if ({bus.stall, bus.PC_en, bus.D_en, bus.E_clr} !== 4'b1001) begin errors++;
      $display("FAIL load_use_stall: got %b want 1001", {bus.stall, bus.PC_en, bus.D_en, bus.E_clr}); end
    step();
    // bubble in E, producer now in M
    bus.E_RegWrite = 0; bus.E_RegAddr = 0; bus.E_Tnew = 0;
    bus.M_RegAddr = 5'd8; bus.M_RegWrite = 1; bus.M_Tnew = 2'd1;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.D_fwd_rs !== 2'd0) begin errors++;
      $display("FAIL load_use_m_tnew1: stall=%b fwd=%0d want 0/0", bus.stall, bus.D_fwd_rs); end
    bus.M_Tnew = 2'd0;
    #1;
    checks++;
    if (bus.D_fwd_rs !== 2'd2) begin errors++;
      $display("FAIL load_use_fwd_m: got %0d want 2", bus.D_fwd_rs); end
    // rt side: Tuse 0 against E Tnew 1 stalls
    idle();
    bus.D_rt = 5'd9; bus.D_Tuse_rt = 2'd0;
    bus.E_RegAddr = 5'd9; bus.E_RegWrite = 1; bus.E_Tnew = 2'd1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++;
      $display("FAIL rt_stall: got %b want 1", bus.stall); end
    // Tuse 3 means operand unused
    bus.D_Tuse_rt = 2'd3; bus.E_Tnew = 2'd2;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++;
      $display("FAIL tuse3_no_stall: got %b want 0", bus.stall); end
    step();
    idle();
  endtask

  task automatic test_priority();
    idle();
    bus.D_rt = 5'd5; bus.D_Tuse_rt = 2'd0;
    bus.E_RegAddr = 5'd5; bus.E_RegWrite = 1; bus.E_Tnew = 0;
    bus.M_RegAddr = 5'd5; bus.M_RegWrite = 1; bus.M_Tnew = 0;
    #1;
    checks++;
    if (bus.D_fwd_rt !== 2'd1 || bus.stall !== 1'b0) begin errors++;
      $display("FAIL prio_e_over_m: fwd=%0d stall=%b want 1/0", bus.D_fwd_rt, bus.stall); end
    bus.D_rt = 0; bus.E_RegAddr = 0; bus.M_RegAddr = 0;
    #1;
    checks++;
    if (bus.D_fwd_rt !== 2'd0 || bus.stall !== 1'b0) begin errors++;
      $display("FAIL zero_reg: fwd=%0d stall=%b want 0/0", bus.D_fwd_rt, bus.stall); end
    bus.E_Tnew = 2'd2; bus.D_rs = 0; bus.D_Tuse_rs = 0;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++;
      $display("FAIL zero_reg_tnew2: stall=%b want 0", bus.stall); end
    step();
    idle();
  endtask

  task automatic test_mult_busy();
    idle();
    bus.D_md_use = 1;
    bus.E_md_start = 1; bus.E_md_is_div = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (bus.stall !== (i < 6)) begin errors++;
        $display("FAIL mult_stall_cycle%0d: got %b want %b", i, bus.stall, (i < 6)); end
      step();
      bus.E_md_start = 0;
    end
    idle();
  endtask

  task automatic test_div_restart();
    idle();
    for (int i = 0; i < 11; i++) begin
      bus.E_md_start  = (i == 0) || (i == 3);
      bus.E_md_is_div = (i == 0);
      #1;
      checks++;
      if (bus.md_busy !== (i < 9)) begin errors++;
        $display("FAIL div_restart_cycle%0d: got %b want %b", i, bus.md_busy, (i < 9)); end
      step();
    end
    idle();
  endtask

  task automatic test_abort();
    logic [31:0] exp_cnt;
    idle();
    bus.D_md_use = 1;
    bus.E_md_start = 1; bus.E_md_is_div = 1;
    step();
    bus.E_md_start = 0;
    step();
    #1;
    checks++;
    if (bus.md_busy !== 1'b1) begin errors++;
      $display("FAIL abort_pre_busy: got %b want 1", bus.md_busy); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.md_busy !== 1'b0 || bus.stall !== 1'b0) begin errors++;
      $display("FAIL abort_busy: busy=%b stall=%b want 0/0", bus.md_busy, bus.stall); end
    checks++;
    if (bus.stall_cnt !== 32'h0) begin errors++;
      $display("FAIL abort_stall_cnt: got %0d want 0", bus.stall_cnt); end
    reset = 1'b1;
    idle();
    bus.D_rs = 5'd4; bus.D_Tuse_rs = 2'd0;
    bus.E_RegAddr = 5'd4; bus.E_RegWrite = 1; bus.E_Tnew = 2'd1;
    for (int i = 0; i < 4; i++) step();
    idle();
    #1;
`ifdef HAZARD_STALL_CNT_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    checks++;
    if (bus.stall_cnt !== exp_cnt) begin errors++;
      $display("FAIL stall_cnt_after4: got %0d want %0d", bus.stall_cnt, exp_cnt); end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle();
    #2;
    test_reset();
    test_load_use();
    test_priority();
    test_mult_busy();
    test_div_restart();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline.
- Compares D-stage source registers against in-flight destinations in E and M, using Tuse/Tnew timing. Generates the stall/flush controls for the PC, D and E pipeline registers and the D/E forwarding selects.
- Owns the multiply/divide busy sequencer: a countdown that holds mfhi/mflo/mthi/mtlo/mult/div instructions in D while the MD unit is running.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after start.
- DIV_CYCLES, 10, busy cycles for div/divu after start.
- CNT_W, 4, width of the busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; block is in reset while reset==0.
- D_rs  in  5  D-stage rs address.
- D_rt  in  5  D-stage rt address.
- D_Tuse_rs  in  2  cycles until D instr needs rs (0..2; 3 = unused).
- D_Tuse_rt  in  2  same for rt.
- D_md_use  in  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- E_RegAddr  in  5  E-stage destination register.
- E_RegWrite  in  1  E instr writes GRF.
- E_Tnew  in  2  cycles until E result exists (0 = available now).
- E_md_start  in  1  E instr is mult/multu/div/divu (one cycle per instr).
- E_md_is_div  in  1  qualifies E_md_start: 1 = div/divu.
- M_RegAddr  in  5  M-stage destination register.
- M_RegWrite  in  1  M instr writes GRF.
- M_Tnew  in  2  cycles until M result exists.
- stall  out  1  hazard stall request.
- PC_en  out  1  PC write enable (= ~stall).
- D_en  out  1  D register enable (= ~stall).
- E_clr  out  1  synchronous clear of E register, i.e. bubble (= stall).
- D_fwd_rs  out  2  rs source: 0 GRF, 1 E_RegData, 2 M_FRegData.
- D_fwd_rt  out  2  same for rt.
- md_busy  out  1  MD unit running.
- stall_cnt  out  32  stall-cycle count (see Optional Feature).

Behaviour:
- Match: a match on rs against stage X requires all of: D_rs != 0, X_RegWrite == 1, X_RegAddr == D_rs. rt is the same with D_rt.
- Register stall, rs: asserted if (E match and D_Tuse_rs < E_Tnew) or (M match and D_Tuse_rs < M_Tnew).
  - Tuse 3 never stalls.
  - Same rule for rt.
- MD stall: D_md_use && md_busy.
- stall: OR of the rs, rt and MD terms. Combinational, same cycle.
- Forwarding, rs:
  - 1 if E match and E_Tnew == 0.
  - Else 2 if M match and M_Tnew == 0.
  - Else 0.
  - Register 0 always selects 0. E has priority over M.
  - Same for rt.
- Busy counter cnt[CNT_W-1:0], updated on rising clk:
  - E_md_start=1: cnt <= (E_md_is_div ? DIV_CYCLES : MULT_CYCLES). This is a reload even if cnt != 0; restart wins over decrement.
  - Else if cnt != 0: cnt <= cnt - 1.
  - Else hold at 0; no wrap below 0.
- md_busy = E_md_start | (cnt != 0).
  - Busy on the start cycle plus exactly N following cycles.
  - A D-stage MD instr behind a mult stalls 1+5 = 6 cycles.
- The start signal is only considered from a real E instruction. A bubble inserted via E_clr has E_md_start=0, so no spurious start.
- Reset (reset==0, asynchronous): cnt=0 and stall_cnt=0 immediately.
  - Outputs are then purely combinational from inputs.
  - With all inputs 0: stall=0, PC_en=1, D_en=1, E_clr=0, D_fwd_rs=D_fwd_rt=0, md_busy=0.
  - Reset mid-MD-operation aborts busy at once.
  - Releasing reset needs no startup cycle.
- Simultaneous register and MD stall: a single stall; stall_cnt increments by 1.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: a 32-bit register increments on each rising clk where stall==1. It wraps 0xFFFFFFFF->0, is cleared by reset, and drives stall_cnt.
- Undefined: no register; stall_cnt tied to 32'h0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold reset=0 with E_md_start=1, E_RegWrite=1 -> cnt stays 0, md_busy=1 only via start, stall_cnt=0. Release -> stall=0 with idle inputs.
- Load-use: D_rs=8, D_Tuse_rs=1; E_RegAddr=8, E_RegWrite=1, E_Tnew=2 -> stall=1, PC_en=0, E_clr=1. Next cycle, M_RegAddr=8, M_Tnew=1 -> stall=0, D_fwd_rs=0. With M_Tnew=0 -> D_fwd_rs=2.
- Priority and $0:
  - E and M both write reg 5 with Tnew=0, D_rt=5 -> D_fwd_rt=1.
  - Same with D_rt=0 -> D_fwd_rt=0, stall=0.
- Mult busy: E_md_start=1, E_md_is_div=0 for one cycle, D_md_use=1 held -> stall=1 for exactly 6 consecutive cycles, then 0.
- Div restart: div start, then mult start 3 cycles later -> cnt reloads to 5; md_busy falls 6 cycles after the second start.
- Abort: mid-div, pulse reset=0 -> md_busy=0 immediately. With HAZARD_STALL_CNT_EN, stall_cnt=0; after 4 stall cycles it reads 4.
